// File: rtl/sugar_field_if.sv
// Bundle of the sugar field's setup, draw, collision and take signals.
// Latency: none (wires only); the take response fields are registered inside sugar_field.
// Backpressure: none; take_req is accepted every run-phase cycle and acked one cycle later.
//
// Ports/modports:
//   master - setup/placement logic plus ant pipeline: drives placement, probe and take_req.
//   slave  - sugar_field: drives placeSugar, collision, hit_idx, take_* and total_empty.
interface sugar_field_if #(
    parameter int IDX_BITS = 2,
    parameter int AMT_BITS = 8,
    parameter int X_BITS   = 10,
    parameter int Y_BITS   = 10
);
    logic                SETUP_PHASE;
    logic                SET;
    logic [IDX_BITS-1:0] set_idx;
    logic [X_BITS-1:0]   in_x;
    logic [Y_BITS-1:0]   in_y;
    logic [AMT_BITS-1:0] in_amt;
    logic [X_BITS-1:0]   writeLoc_x;
    logic [Y_BITS-1:0]   writeLoc_y;
    logic [X_BITS-1:0]   collide_x;
    logic [Y_BITS-1:0]   collide_y;
    logic                take_req;
    logic                placeSugar;
    logic                collision;
    logic [IDX_BITS-1:0] hit_idx;
    logic                take_ack;
    logic                take_ok;
    logic [IDX_BITS-1:0] take_idx;
    logic                total_empty;

    modport master (
        output SETUP_PHASE, SET, set_idx, in_x, in_y, in_amt,
        output writeLoc_x, writeLoc_y, collide_x, collide_y, take_req,
        input  placeSugar, collision, hit_idx, take_ack, take_ok, take_idx, total_empty
    );

    modport slave (
        input  SETUP_PHASE, SET, set_idx, in_x, in_y, in_amt,
        input  writeLoc_x, writeLoc_y, collide_x, collide_y, take_req,
        output placeSugar, collision, hit_idx, take_ack, take_ok, take_idx, total_empty
    );
endinterface

// File: rtl/sugar_field.sv
// Field of N_PATCHES square sugar patches with finite stock: collision/draw queries and a take handshake.
// Latency: placeSugar/collision/hit_idx combinational; take_ack/ok/idx and total_empty one cycle after the request.
// Backpressure: none; every run-phase take_req is acknowledged, back-to-back requests allowed.
//
// Ports: Clk, RESET (async, active-high), bus (sugar_field_if.slave).
// Optional feature: define SUGAR_REGROW_EN to build the periodic regrowth counter (REGROW_PERIOD).
module sugar_field #(
    parameter int N_PATCHES     = 4,
    parameter int IDX_BITS      = 2,
    parameter int AMT_BITS      = 8,
    parameter int RADIUS        = 8,
    parameter int REGROW_PERIOD = 1024,
    parameter int X_BITS        = 10,
    parameter int Y_BITS        = 10
) (
    input  logic          Clk,
    input  logic          RESET,
    sugar_field_if.slave  bus
);
    localparam int IDX_EXP = (N_PATCHES > 1) ? $clog2(N_PATCHES) : 1;

    if (IDX_BITS != IDX_EXP || REGROW_PERIOD < 1) begin : g_param_check
        $error("sugar_field: IDX_BITS must equal clog2(N_PATCHES) (min 1) and REGROW_PERIOD >= 1");
    end

    localparam logic [X_BITS-1:0]   RAD_X   = X_BITS'(RADIUS);
    localparam logic [Y_BITS-1:0]   RAD_Y   = Y_BITS'(RADIUS);
    localparam logic [AMT_BITS-1:0] AMT_MAX = '1;

    logic [X_BITS-1:0]   x_q   [N_PATCHES];
    logic [Y_BITS-1:0]   y_q   [N_PATCHES];
    logic [AMT_BITS-1:0] amt_q [N_PATCHES];
    logic [X_BITS-1:0]   x_d   [N_PATCHES];
    logic [Y_BITS-1:0]   y_d   [N_PATCHES];
    logic [AMT_BITS-1:0] amt_d [N_PATCHES];

    logic                take_ack_q, take_ok_q, total_empty_q;
    logic [IDX_BITS-1:0] take_idx_q;
    logic                total_empty_d;

    logic                coll, place;
    logic [IDX_BITS-1:0] hit;
    logic                take_acc, take_hit, tick;

    // Unsigned distance test without wrap: the smaller value is always subtracted from the larger.
    function automatic logic near_x(input logic [X_BITS-1:0] a, input logic [X_BITS-1:0] b);
        logic [X_BITS-1:0] d;
        d = (a >= b) ? a - b : b - a;
        return d <= RAD_X;
    endfunction

    function automatic logic near_y(input logic [Y_BITS-1:0] a, input logic [Y_BITS-1:0] b);
        logic [Y_BITS-1:0] d;
        d = (a >= b) ? a - b : b - a;
        return d <= RAD_Y;
    endfunction

    // Walk slots from highest to lowest so the lowest stocked overlapping slot ends up in hit.
    always_comb begin
        coll  = 1'b0;
        place = 1'b0;
        hit   = '0;
        for (int i = N_PATCHES - 1; i >= 0; i--) begin
            if (amt_q[i] != '0) begin
                if (near_x(x_q[i], bus.collide_x) && near_y(y_q[i], bus.collide_y)) begin
                    coll = 1'b1;
                    hit  = IDX_BITS'(i);
                end
                if (near_x(x_q[i], bus.writeLoc_x) && near_y(y_q[i], bus.writeLoc_y)) begin
                    place = 1'b1;
                end
            end
        end
    end

    assign take_acc = !bus.SETUP_PHASE && bus.take_req;
    assign take_hit = take_acc && coll;

`ifdef SUGAR_REGROW_EN
    localparam int CNT_BITS = (REGROW_PERIOD > 1) ? $clog2(REGROW_PERIOD) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(REGROW_PERIOD - 1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Counter only advances in run phase, so setup holds regrowth off.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!bus.SETUP_PHASE) begin
            tick  = (cnt_q == CNT_LAST);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tick = 1'b0;
`endif

    // Regrowth applied first, then the debit: a tick and a take on the same slot cancel out.
    always_comb begin
        for (int i = 0; i < N_PATCHES; i++) begin
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            amt_d[i] = amt_q[i];
            if (tick && amt_q[i] != '0 && amt_q[i] != AMT_MAX) amt_d[i] = amt_q[i] + 1'b1;
            if (take_hit && hit == IDX_BITS'(i))              amt_d[i] = amt_d[i] - 1'b1;
        end
        if (bus.SETUP_PHASE && bus.SET) begin
            x_d[bus.set_idx]   = bus.in_x;
            y_d[bus.set_idx]   = bus.in_y;
            amt_d[bus.set_idx] = bus.in_amt;
        end
        total_empty_d = 1'b1;
        for (int i = 0; i < N_PATCHES; i++) begin
            if (amt_d[i] != '0) total_empty_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_PATCHES; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                amt_q[i] <= '0;
            end
            take_ack_q    <= 1'b0;
            take_ok_q     <= 1'b0;
            take_idx_q    <= '0;
            total_empty_q <= 1'b1;
        end else begin
            for (int i = 0; i < N_PATCHES; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                amt_q[i] <= amt_d[i];
            end
            take_ack_q    <= take_acc;
            take_ok_q     <= take_hit;
            take_idx_q    <= take_hit ? hit : '0;
            total_empty_q <= total_empty_d;
        end
    end

    assign bus.placeSugar  = place;
    assign bus.collision   = coll;
    assign bus.hit_idx     = hit;
    assign bus.take_ack    = take_ack_q;
    assign bus.take_ok     = take_ok_q;
    assign bus.take_idx    = take_idx_q;
    assign bus.total_empty = total_empty_q;
endmodule

// File: tb/tb_sugar_field.sv
// Self-checking bench for sugar_field: scoreboard of expected take responses plus direct probes.
// Latency: responses checked one cycle after each driven take_req.
// Backpressure: none; takes may be issued back-to-back.
module tb_sugar_field;
    logic Clk = 1'b0;
    logic RESET = 1'b1;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ok;
        logic [1:0] idx;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];

    sugar_field_if bus ();

    sugar_field #(.REGROW_PERIOD(1024)) u_dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Each cycle: a pending expectation must be acked now, otherwise the response must stay idle.
    always @(posedge Clk) begin
        #1;
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack",     32'(bus.take_ack), 32'd1);
                check("take_ok", 32'(bus.take_ok),  32'(e.ok));
                check("take_idx", 32'(bus.take_idx), 32'(e.idx));
            end else begin
                check("idle_ack", 32'(bus.take_ack), 32'd0);
                check("idle_ok",  32'(bus.take_ok),  32'd0);
                check("idle_idx", 32'(bus.take_idx), 32'd0);
            end
        end
    end

    task automatic setup_slot(input int idx, input int x, input int y, input int amt);
        bus.SETUP_PHASE = 1'b1;
        bus.SET         = 1'b1;
        bus.set_idx     = 2'(idx);
        bus.in_x        = 10'(x);
        bus.in_y        = 10'(y);
        bus.in_amt      = 8'(amt);
        @(negedge Clk);
        bus.SET         = 1'b0;
        bus.SETUP_PHASE = 1'b0;
    endtask

    task automatic take(input int x, input int y, input logic ok, input int idx);
        exp_t e;
        bus.collide_x = 10'(x);
        bus.collide_y = 10'(y);
        bus.take_req  = 1'b1;
        e.ok  = ok;
        e.idx = 2'(idx);
        sb_q.push_back(e);
        @(negedge Clk);
        bus.take_req = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic c, input int h);
        bus.collide_x = 10'(x);
        bus.collide_y = 10'(y);
        #1;
        check({tag, "_coll"}, 32'(bus.collision), 32'(c));
        check({tag, "_hit"},  32'(bus.hit_idx),   32'(h));
    endtask

    task automatic draw(input string tag, input int x, input int y, input logic p);
        bus.writeLoc_x = 10'(x);
        bus.writeLoc_y = 10'(y);
        #1;
        check(tag, 32'(bus.placeSugar), 32'(p));
    endtask

`ifdef SUGAR_REGROW_EN
    exp_t sb2_q[$];
    sugar_field_if bus2 ();

    sugar_field #(.REGROW_PERIOD(4)) u_dut_rg (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus2)
    );

    always @(posedge Clk) begin
        #1;
        if (mon_en) begin
            if (sb2_q.size() > 0) begin
                exp_t e;
                e = sb2_q.pop_front();
                check("rg_ack", 32'(bus2.take_ack), 32'd1);
                check("rg_ok",  32'(bus2.take_ok),  32'(e.ok));
                check("rg_idx", 32'(bus2.take_idx), 32'(e.idx));
            end else begin
                check("rg_idle_ack", 32'(bus2.take_ack), 32'd0);
            end
        end
    end

    task automatic take2(input logic ok);
        exp_t e;
        bus2.collide_x = 10'd60;
        bus2.collide_y = 10'd60;
        bus2.take_req  = 1'b1;
        e.ok  = ok;
        e.idx = 2'd0;
        sb2_q.push_back(e);
        @(negedge Clk);
        bus2.take_req = 1'b0;
    endtask
`endif

    initial begin
        bus.SETUP_PHASE = 1'b0; bus.SET = 1'b0; bus.set_idx = '0;
        bus.in_x = '0; bus.in_y = '0; bus.in_amt = '0;
        bus.writeLoc_x = '0; bus.writeLoc_y = '0;
        bus.collide_x = '0; bus.collide_y = '0; bus.take_req = 1'b0;
`ifdef SUGAR_REGROW_EN
        // Held in setup so its regrowth counter stays at 0 until its own test.
        bus2.SETUP_PHASE = 1'b1; bus2.SET = 1'b0; bus2.set_idx = '0;
        bus2.in_x = '0; bus2.in_y = '0; bus2.in_amt = '0;
        bus2.writeLoc_x = '0; bus2.writeLoc_y = '0;
        bus2.collide_x = '0; bus2.collide_y = '0; bus2.take_req = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_ack",   32'(bus.take_ack),    32'd0);
        check("rst_ok",    32'(bus.take_ok),     32'd0);
        check("rst_idx",   32'(bus.take_idx),    32'd0);
        check("rst_empty", 32'(bus.total_empty), 32'd1);
        check("rst_place", 32'(bus.placeSugar),  32'd0);
        probe("rst", 0, 0, 1'b0, 0);
        @(negedge Clk);
        RESET  = 1'b0;
        mon_en = 1'b1;
        @(negedge Clk);
        probe("idle", 8, 8, 1'b0, 0);

        // Placement, boundaries, draw and lifetime of slot 0
        setup_slot(0, 100, 50, 3);
        check("stocked_empty", 32'(bus.total_empty), 32'd0);
        probe("edge_in",  108, 42, 1'b1, 0);
        probe("edge_out", 109, 50, 1'b0, 0);
        draw("draw_in",  92, 58, 1'b1);
        draw("draw_out", 91, 58, 1'b0);
        take(100, 50, 1'b1, 0);
        take(100, 50, 1'b1, 0);
        take(100, 50, 1'b1, 0);
        take(100, 50, 1'b0, 0);
        check("drained_empty", 32'(bus.total_empty), 32'd1);
        probe("inert", 100, 50, 1'b0, 0);
        draw("draw_inert", 100, 50, 1'b0);

        // Overlap priority: slot 1 first, then slot 2 holding 5 units
        setup_slot(1, 20, 20, 1);
        setup_slot(2, 22, 20, 5);
        probe("overlap", 21, 20, 1'b1, 1);
        take(21, 20, 1'b1, 1);
        for (int k = 0; k < 5; k++) take(21, 20, 1'b1, 2);
        take(21, 20, 1'b0, 0);
        check("overlap_empty", 32'(bus.total_empty), 32'd1);

        // take_req ignored in setup phase: the single unit survives
        setup_slot(0, 50, 50, 1);
        bus.SETUP_PHASE = 1'b1;
        bus.collide_x   = 10'd50;
        bus.collide_y   = 10'd50;
        bus.take_req    = 1'b1;
        @(negedge Clk);
        bus.take_req    = 1'b0;
        bus.SETUP_PHASE = 1'b0;
        take(50, 50, 1'b1, 0);
        take(50, 50, 1'b0, 0);

        // Reset on the cycle after a take clears the pulse immediately and wipes slots
        setup_slot(3, 200, 200, 2);
        take(200, 200, 1'b1, 3);
        RESET = 1'b1;
        #1;
        check("arst_ack",   32'(bus.take_ack),    32'd0);
        check("arst_ok",    32'(bus.take_ok),     32'd0);
        check("arst_idx",   32'(bus.take_idx),    32'd0);
        check("arst_empty", 32'(bus.total_empty), 32'd1);
        probe("arst_slot", 200, 200, 1'b0, 0);
        @(negedge Clk);
        RESET = 1'b0;
        @(negedge Clk);
        probe("post_rst", 200, 200, 1'b0, 0);

`ifdef SUGAR_REGROW_EN
        // Regrowth with period 4 on slot 0 (amt 2); slot 1 left at 0
        bus2.SET = 1'b1; bus2.set_idx = 2'd0;
        bus2.in_x = 10'd60; bus2.in_y = 10'd60; bus2.in_amt = 8'd2;
        @(negedge Clk);
        bus2.SET = 1'b0;
        bus2.SETUP_PHASE = 1'b0;
        repeat (7) @(negedge Clk);   // tick at 4th run edge -> 3
        take2(1'b1);                 // 8th edge: tick and take cancel -> 3
        take2(1'b1);
        take2(1'b1);
        take2(1'b1);                 // drained to 0
        take2(1'b0);                 // tick edge: empty slot does not regrow
        repeat (5) @(negedge Clk);
        take2(1'b0);
        check("rg_empty", 32'(bus2.total_empty), 32'd1);
        bus2.collide_x = 10'd300;
        bus2.collide_y = 10'd300;
        #1;
        check("rg_zero_slot", 32'(bus2.collision), 32'd0);
`endif

        repeat (2) @(negedge Clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
